// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the requesters and the ALU scheduler.
// Requesters use the master modport; the scheduler uses the slave modport.
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters.
// One op in flight: IDLE (grant) -> EXEC (capture result) -> RESP (hold).
module alu_rr_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 8,
  parameter int OP_W     = 4,
  parameter int OP_LEGAL = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_scheduler_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic               gnt_hit;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  int                 scan_idx;

  // First valid requester at or after rr_ptr, wrapping; descending scan lets the nearest win.
  always_comb begin
    gnt_hit  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (bus.req_valid[scan_idx]) begin
        gnt_hit = 1'b1;
        gnt_idx = PTR_W'(scan_idx);
      end
    end
  end

  assign gnt_oh = NUM_REQ'(1) << gnt_idx;

  assign bus.req_ready = (state_q == IDLE && gnt_hit) ? gnt_oh : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign busy          = busy_q;

  // Next-state and registered-output computation for the issue FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_hit) begin
          alu_a_d  = bus.req_a[gnt_idx*DATA_W +: DATA_W];
          alu_b_d  = bus.req_b[gnt_idx*DATA_W +: DATA_W];
          alu_op_d = bus.req_op[gnt_idx*OP_W +: OP_W];
          owner_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1))
                   ? '0 : gnt_idx + PTR_W'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_res;
        rsp_err_d   = (alu_op_q >= OP_W'(OP_LEGAL));
        rsp_valid_d = NUM_REQ'(1) << owner_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
